regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the next-generation core, successor to the single-write, two-read register file. It provides NRD combinational read ports, NWR synchronous write ports with fixed priority, optional write-to-read bypass, and a per-register busy scoreboard that decode uses for RAW hazard detection. It sits between decode (read and allocate) and writeback (write and release). Register 0 is hardwired to zero.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of registers; power of two, 2..64
- AW, $clog2(NREG), address width; derived, not overridden
- NRD, 2, read ports, 1..4
- NWR, 2, write ports, 1..2
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see registered contents only

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all registers and busy bits
- rs_addr  in  NRD*AW  read addresses; port i uses [i*AW +: AW]
- rs_data  out  NRD*XLEN  read data, port i uses [i*XLEN +: XLEN]
- rs_busy  out  NRD  port i register has an outstanding producer
- w_en  in  NWR  write enable per port
- w_addr  in  NWR*AW  write addresses
- w_data  in  NWR*XLEN  write data
- alloc_en  in  1  mark alloc_addr busy (decode issued a producer)
- alloc_addr  in  AW  register being allocated
- busy_vec  out  NREG  raw scoreboard state; bit 0 always 0

## Operation
- Storage: NREG x XLEN flops plus NREG busy flops. Register 0 has no storage: reads return 0, writes and allocates to address 0 are dropped, and busy[0] is 0.
- Write: on the rising edge, for each port p with w_en[p]=1 and w_addr[p]!=0, reg[w_addr[p]] <= w_data[p].
- Write collision: if both ports write the same address in one cycle, port 1 wins. The loser is silently discarded; no error flag.
- Scoreboard set: alloc_en=1 and alloc_addr!=0 sets busy[alloc_addr] at the edge.
- Scoreboard clear: any enabled write to address a clears busy[a] at the edge.
- Simultaneous alloc and write to the same address: set wins, so busy stays 1 because a new producer supersedes the retiring one. The data write still occurs.
- Read, BYPASS=1: if any enabled write this cycle targets rs_addr[i]!=0, rs_data[i] is that write's w_data (port 1 over port 0). Otherwise it is reg[rs_addr[i]].
- Read, BYPASS=0: rs_data[i] = reg[rs_addr[i]], the registered contents only.
- rs_busy[i] = busy[rs_addr[i]] & ~(BYPASS & write hit on rs_addr[i] this cycle). An alloc in the current cycle does not affect rs_busy until the next cycle.
- Read ports are independent. Any number of ports may read the same address.

## Timing
- Reads and rs_busy are purely combinational from rs_addr, register state, and (BYPASS=1) the write ports. This is zero-cycle latency.
- Writes and scoreboard updates take effect at the next rising edge and are visible to BYPASS=0 reads one cycle later.
- Reset asserted at any time, including mid-write: all registers go to 0 and busy_vec goes to 0 immediately, without waiting for a clock edge.
- While reset is high, writes and allocs are ignored. rs_data is 0 for all addresses and rs_busy is 0.
- First write accepted on the first rising edge after reset deasserts.
- No X propagation: out-of-range addresses are impossible because NREG = 2^AW.

## Test plan
- Reset then read: assert reset mid-run after writing reg5=32'hDEAD_BEEF → rs_data for address 5 is 0 and busy_vec is 0 while reset is high, with no clock edge needed.
- Basic write/read (BYPASS=0): port 0 writes reg3=32'h1234_5678 → rs_data for address 3 is unchanged in the same cycle and reads 32'h1234_5678 on the next cycle. A write of 32'hFFFF_FFFF to reg0 → reg0 still reads 0.
- Collision: port 0 writes reg7=32'hAAAA_AAAA and port 1 writes reg7=32'h5555_5555 in the same cycle → next cycle reg7 reads 32'h5555_5555. With BYPASS=1, the same-cycle read returns 32'h5555_5555.
- Scoreboard: alloc reg9 → the next cycle rs_busy=1 for a read of 9. Port 1 writes reg9=32'h0000_0042 → with BYPASS=1 in the same cycle rs_busy=0 and rs_data=32'h0000_0042, and busy_vec[9]=0 afterwards.
- Alloc/write race: alloc reg4 and write reg4=32'h0000_0010 in the same cycle while busy[4]=1 → next cycle busy_vec[4]=1 and reg4 reads 32'h0000_0010.
- Multi-port: NRD=4, all four ports read addresses 1, 1, 2, 0 after writing reg1=32'h1 and reg2=32'h2 → outputs are 1, 1, 2, 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, NWR prioritised
// write ports, optional write-to-read bypass and a per-register busy scoreboard.

module regfile_mp_rdport #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                      reset,
  input  logic [AW-1:0]             addr,
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [NREG-1:0]           busy,
  input  logic [NWR-1:0]            w_en,
  input  logic [NWR-1:0][AW-1:0]    w_addr,
  input  logic [NWR-1:0][XLEN-1:0]  w_data,
  output logic [XLEN-1:0]           data,
  output logic                      busy_o
);
  logic            hit;
  logic [XLEN-1:0] fwd;

  // Higher-numbered write ports are scanned last so they take priority.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int p = 0; p < NWR; p++) begin
      if (w_en[p] && w_addr[p] == addr && addr != '0) begin
        hit = 1'b1;
        fwd = w_data[p];
      end
    end
  end

  always_comb begin
    data   = regs[addr];
    busy_o = busy[addr];
    if (BYPASS != 0 && hit) begin
      data   = fwd;
      busy_o = 1'b0;
    end
    // Forwarded write data must not leak out while the file is held in reset.
    if (reset) begin
      data   = '0;
      busy_o = 1'b0;
    end
  end
endmodule

module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rs_addr,
  output logic [NRD*XLEN-1:0]  rs_data,
  output logic [NRD-1:0]       rs_busy,
  input  logic [NWR-1:0]       w_en,
  input  logic [NWR*AW-1:0]    w_addr,
  input  logic [NWR*XLEN-1:0]  w_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic [NREG-1:0]      busy_vec
);
  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;
  logic [NWR-1:0][AW-1:0]    w_addr_a;
  logic [NWR-1:0][XLEN-1:0]  w_data_a;
  logic [NRD-1:0][AW-1:0]    rs_addr_a;
  logic [NRD-1:0][XLEN-1:0]  rs_data_a;

  assign w_addr_a  = w_addr;
  assign w_data_a  = w_data;
  assign rs_addr_a = rs_addr;
  assign rs_data   = rs_data_a;
  assign busy_vec  = busy;

  // Later assignments win: port 1 over port 0, and a same-edge alloc over a write's clear.
  // Entry 0 is only ever loaded with zero, so it reads as a hardwired zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (w_en[p] && w_addr_a[p] != '0) begin
          regs[w_addr_a[p]] <= w_data_a[p];
          busy[w_addr_a[p]] <= 1'b0;
        end
      end
      if (alloc_en && alloc_addr != '0)
        busy[alloc_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_mp_rdport #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW), .NWR(NWR), .BYPASS(BYPASS)
    ) u_rd (
      .reset  (reset),
      .addr   (rs_addr_a[i]),
      .regs   (regs),
      .busy   (busy),
      .w_en   (w_en),
      .w_addr (w_addr_a),
      .w_data (w_data_a),
      .data   (rs_data_a[i]),
      .busy_o (rs_busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: one non-bypass and one bypass instance share stimulus;
// expectations are queued per cycle and drained by an independent monitor.

module tb_regfile_mp;
  localparam int XLEN = 32, NREG = 32, AW = 5, NRD = 4, NWR = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rd_a, rd_b;
  logic [NRD-1:0]      rb_a, rb_b;
  logic [NWR-1:0]      w_en;
  logic [NWR*AW-1:0]   w_addr;
  logic [NWR*XLEN-1:0] w_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic [NREG-1:0]     bv_a, bv_b;

  always #5 clock = ~clock;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nb (
    .clock(clock), .reset(reset), .rs_addr(rs_addr), .rs_data(rd_a), .rs_busy(rb_a),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .busy_vec(bv_a));

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_by (
    .clock(clock), .reset(reset), .rs_addr(rs_addr), .rs_data(rd_b), .rs_busy(rb_b),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .busy_vec(bv_b));

  // kind: 0/1 rs_data (no-bypass/bypass), 2/3 rs_busy, 4/5 busy_vec
  typedef struct { string name; int kind; int port; logic [31:0] exp; } exp_t;
  exp_t q[$];
  int   total = 0, bad = 0;
  event chk_ev;

  function automatic logic [31:0] actual(int kind, int port);
    case (kind)
      0: return rd_a[port*XLEN +: XLEN];
      1: return rd_b[port*XLEN +: XLEN];
      2: return {31'b0, rb_a[port]};
      3: return {31'b0, rb_b[port]};
      4: return bv_a;
      5: return bv_b;
      default: return 32'hx;
    endcase
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clock or chk_ev);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = actual(e.kind, e.port);
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s (%s) port=%0d got=%h want=%h", e.name,
                   (e.kind % 2) ? "bypass" : "nobypass", e.port, act, e.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    w_en     = '0;
    alloc_en = 1'b0;
  endtask

  task automatic wr(int p, int a, logic [31:0] d);
    w_en[p]                = 1'b1;
    w_addr[p*AW +: AW]     = AW'(a);
    w_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(int p, int a);
    rs_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic ex(string n, int k, int p, logic [31:0] exp_nb, logic [31:0] exp_by);
    q.push_back('{name: n, kind: k,     port: p, exp: exp_nb});
    q.push_back('{name: n, kind: k + 1, port: p, exp: exp_by});
  endtask

  initial begin : stim
    rs_addr = '0; w_en = '0; w_addr = '0; w_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;

    step(); rd(0, 5);
    ex("rst_data", 0, 0, 0, 0); ex("rst_bv", 4, 0, 0, 0);
    step(); reset = 1'b0;
    wr(0, 5, 32'hDEAD_BEEF); alloc_en = 1'b1; alloc_addr = 5'd6;
    step(); rd(1, 6);
    ex("w5", 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    ex("bv6", 4, 0, 32'h40, 32'h40); ex("busy6", 2, 1, 1, 1);
    // Mid-cycle reset, after the negedge check and before the next rising edge.
    #6; reset = 1'b1; wr(0, 5, 32'h1111_1111);
    #1;
    ex("midrst_data", 0, 0, 0, 0); ex("midrst_bv", 4, 0, 0, 0);
    ex("midrst_busy", 2, 1, 0, 0);
    ->chk_ev;
    step(); step(); reset = 1'b0;
    step();
    ex("post_rst_data", 0, 0, 0, 0); ex("post_rst_bv", 4, 0, 0, 0);

    step(); wr(0, 3, 32'h1234_5678); wr(1, 0, 32'hFFFF_FFFF); rd(0, 3); rd(1, 0);
    ex("w3_same", 0, 0, 0, 32'h1234_5678); ex("r0_same", 0, 1, 0, 0);
    step();
    ex("w3_next", 0, 0, 32'h1234_5678, 32'h1234_5678); ex("r0_next", 0, 1, 0, 0);

    step(); wr(0, 7, 32'hAAAA_AAAA); wr(1, 7, 32'h5555_5555); rd(0, 7);
    ex("coll_same", 0, 0, 0, 32'h5555_5555);
    step();
    ex("coll_next", 0, 0, 32'h5555_5555, 32'h5555_5555);

    step(); alloc_en = 1'b1; alloc_addr = 5'd9; rd(0, 9);
    ex("alloc_same", 2, 0, 0, 0);
    step();
    ex("alloc_next", 2, 0, 1, 1); ex("bv9", 4, 0, 32'h200, 32'h200);
    step(); wr(1, 9, 32'h0000_0042);
    ex("wb9_busy", 2, 0, 1, 0); ex("wb9_data", 0, 0, 0, 32'h42);
    step();
    ex("bv9_clr", 4, 0, 0, 0); ex("r9", 0, 0, 32'h42, 32'h42); ex("r9_busy", 2, 0, 0, 0);

    step(); alloc_en = 1'b1; alloc_addr = 5'd4;
    step(); alloc_en = 1'b1; alloc_addr = 5'd4; wr(0, 4, 32'h0000_0010); rd(2, 4);
    ex("race_busy", 2, 2, 1, 0); ex("race_data", 0, 2, 0, 32'h10);
    step();
    ex("race_bv", 4, 0, 32'h10, 32'h10); ex("race_r4", 0, 2, 32'h10, 32'h10);
    ex("race_rbusy", 2, 2, 1, 1);

    step(); wr(0, 1, 32'h1); wr(1, 2, 32'h2); alloc_en = 1'b1; alloc_addr = 5'd0;
    step(); rd(0, 1); rd(1, 1); rd(2, 2); rd(3, 0);
    ex("mp0", 0, 0, 1, 1); ex("mp1", 0, 1, 1, 1); ex("mp2", 0, 2, 2, 2); ex("mp3", 0, 3, 0, 0);
    ex("mp_bv", 4, 0, 32'h10, 32'h10);
    step(); wr(0, 4, 32'h99);
    step();
    ex("rel_bv", 4, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
